n_way_arb_mux: RTL and testbench
================================

N_WAY_ARB_MUX -- requirements
Module: n_way_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width per channel in bits.
REQ-002 The block SHALL have parameter NUM_IN, default 4, giving the input channel count (range 2..16).
REQ-003 The block SHALL have derived localparam SEL_W = clog2(NUM_IN), default 2.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = SELECT (steered by op), 1 = ROUND_ROBIN.
REQ-007 The block SHALL have port op, input, SEL_W bits: channel select, used in SELECT mode only.
REQ-008 The block SHALL have port in_data, input, NUM_IN*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_valid, input, NUM_IN bits: channel i offers a word.
REQ-010 The block SHALL have port in_ready, output, NUM_IN bits: channel i word accepted this cycle.
REQ-011 The block SHALL have port out, output, WIDTH bits: registered selected word.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out holds an undelivered word.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream consumes out this cycle.
REQ-014 The block SHALL have port out_sel, output, SEL_W bits: source channel index of the word in out.

Function
REQ-015 Output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_accept SHALL be (state==EMPTY) or (out_ready==1), so a new word can be loaded in the same cycle the current word drains.
REQ-017 In SELECT mode, grant SHALL go to channel op if in_valid[op]=1 and op<NUM_IN; otherwise there SHALL be no grant.
REQ-018 In ROUND_ROBIN mode, grant SHALL go to the first channel with in_valid=1, searching from (rr_ptr+1) mod NUM_IN upward with wrap-around; with no valid channel there SHALL be no grant.
REQ-019 in_ready SHALL be combinational, one-hot or zero: in_ready[g]=1 only when a grant to g exists and can_accept=1.
REQ-020 On a transfer (in_ready[g]=1), the next edge SHALL load out=in_data[g], out_sel=g and state=FULL; latency is exactly 1 cycle.
REQ-021 rr_ptr SHALL update to g only on a ROUND_ROBIN-mode transfer; a SELECT-mode transfer leaves rr_ptr unchanged.
REQ-022 If FULL with out_ready=0, out, out_sel and out_valid SHALL hold unchanged and in_ready SHALL be all zero.
REQ-023 If FULL with out_ready=1 and no grant, the next state SHALL be EMPTY; out and out_sel SHALL retain their last values.
REQ-024 out_ready while EMPTY SHALL have no effect.
REQ-025 A mode or op change SHALL take effect on the grant computed in the same cycle and SHALL never alter a word already held in out.
REQ-026 in_data of non-granted channels SHALL never reach out.

Reset
REQ-027 When reset=0 at a rising edge: out=0, out_sel=0, out_valid=0, state=EMPTY, rr_ptr=NUM_IN-1 (so the first ROUND_ROBIN grant favours channel 0).
REQ-028 While reset=0, in_ready SHALL be all zero; reset asserted mid-transfer discards any held word with no delivery.

Structure
REQ-029 Shared package SHALL hold the mode encodings MODE_SELECT=1'b0 and MODE_RR=1'b1, the FSM state enum {EMPTY, FULL}, and a clog2 function.
REQ-030 The round-robin priority search SHALL be a sub-module rr_grant (inputs: valid vector and pointer; outputs: grant index and grant-found flag), instantiated once.
REQ-031 The implementation SHALL have no latches; all registers SHALL be in one clocked process with synchronous reset.

Verification (WIDTH=16, NUM_IN=4, in_data ch0..3 = 0x0000, 0x0001, 0x0002, 0x0003)
REQ-032 Reset held low for 100 cycles, then released -> out=0, out_valid=0, in_ready=0000 throughout reset and on the first cycle after release with no valid inputs.
REQ-033 SELECT mode, op sweeps 0,1,2,3, all in_valid=1, out_ready=1 -> one cycle after each transfer, out=0x0000, 0x0001, 0x0002, 0x0003 and out_sel=0, 1, 2, 3.
REQ-034 ROUND_ROBIN mode, in_valid=1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with one word per cycle.
REQ-035 ROUND_ROBIN mode, in_valid=1010, out_ready=0 for 3 cycles, then 1 -> first word (ch1, 0x0001) held 3 cycles with in_ready=0000, then ch3 (0x0003), then ch1.
REQ-036 SELECT mode with op=2 and in_valid[2]=0 -> no transfer and out_valid stays 0; set in_valid[2]=1 -> out=0x0002 on the next cycle.
REQ-037 Reset asserted while FULL with out_ready=0 -> out_valid=0 and out=0 next cycle; the held word is never delivered.

Source files
------------

// File: rtl/n_way_arb_mux_pkg.sv
// Shared definitions for the n-way arbitrating mux: mode encodings,
// output-stage state enum and the select-width helper.
package n_way_arb_mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Minimum of 1 bit so a 1-channel width never collapses to zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/n_way_arb_mux_rr_grant.sv
// Round-robin priority search: first valid channel after ptr, with wrap.
module rr_grant #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              found
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_IN; i++) begin
      idx = (32'(ptr) + i) % NUM_IN;
      if (!found && valid[idx]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/n_way_arb_mux.sv
// N-channel mux with SELECT / ROUND_ROBIN arbitration feeding a one-word
// registered output stage with valid/ready handshake.
module n_way_arb_mux
  import n_way_arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  state_t              state, state_next;
  logic [SEL_W-1:0]    rr_ptr, rr_gnt, gnt;
  logic                rr_found, found, can_accept, xfer;
  logic [2**SEL_W-1:0] valid_ext;

  rr_grant #(
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_rr_grant (
    .valid(in_valid),
    .ptr  (rr_ptr),
    .grant(rr_gnt),
    .found(rr_found)
  );

  always_comb begin
    // Zero-extended valid vector makes op values beyond NUM_IN-1 read as no request.
    valid_ext                = '0;
    valid_ext[NUM_IN-1:0]    = in_valid;
    gnt                      = op;
    found                    = valid_ext[op];
    if (mode == MODE_RR) begin
      gnt   = rr_gnt;
      found = rr_found;
    end
    can_accept = (state == EMPTY) || out_ready;
    xfer       = reset && found && can_accept;
    in_ready   = '0;
    if (xfer) in_ready[gnt] = 1'b1;
    state_next = state;
    if (xfer)           state_next = FULL;
    else if (out_ready) state_next = EMPTY;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= EMPTY;
      out     <= '0;
      out_sel <= '0;
      rr_ptr  <= SEL_W'(NUM_IN - 1);
    end else begin
      state <= state_next;
      if (xfer) begin
        out     <= in_data[gnt*WIDTH +: WIDTH];
        out_sel <= gnt;
        if (mode == MODE_RR) rr_ptr <= gnt;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_n_way_arb_mux.sv
// Scoreboard bench for n_way_arb_mux: a reference model predicts grants,
// pushes each accepted word and pops it when the DUT delivers it.
module tb_n_way_arb_mux;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    mode;
  logic [SEL_W-1:0]        op;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } item_t;

  item_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic             m_full;
  logic [WIDTH-1:0] m_out;
  logic [SEL_W-1:0] m_sel;
  logic [SEL_W-1:0] m_rr;

  always #5 clock = ~clock;

  n_way_arb_mux #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mode     (mode),
    .op       (op),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at negedge, advance model, then move to just after the next posedge.
  task automatic cycle();
    logic [SEL_W-1:0]  g;
    logic              fnd;
    logic              can;
    logic [NUM_IN-1:0] exp_rdy;
    int unsigned       idx;
    item_t             it;
    @(negedge clock);
    check_eq("out_valid", 32'(out_valid), 32'(m_full));
    check_eq("out", 32'(out), 32'(m_out));
    check_eq("out_sel", 32'(out_sel), 32'(m_sel));
    if (!reset) begin
      check_eq("in_ready_rst", 32'(in_ready), 32'(0));
      m_full = 1'b0;
      m_out  = '0;
      m_sel  = '0;
      m_rr   = SEL_W'(NUM_IN - 1);
      sb.delete();
    end else begin
      g       = '0;
      fnd     = 1'b0;
      exp_rdy = '0;
      if (mode == 1'b0) begin
        g   = op;
        fnd = in_valid[op];
      end else begin
        for (int k = 1; k <= NUM_IN; k++) begin
          idx = (32'(m_rr) + 32'(k)) % NUM_IN;
          if (!fnd && in_valid[idx]) begin
            fnd = 1'b1;
            g   = SEL_W'(idx);
          end
        end
      end
      can = !m_full || out_ready;
      if (m_full && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 32'(sb.size()), 32'(1));
        end else begin
          it = sb.pop_front();
          check_eq("deliver_data", 32'(out), 32'(it.data));
          check_eq("deliver_sel", 32'(out_sel), 32'(it.sel));
        end
        m_full = 1'b0;
      end
      if (fnd && can) begin
        exp_rdy[g] = 1'b1;
        it.data    = in_data[g*WIDTH +: WIDTH];
        it.sel     = g;
        sb.push_back(it);
        m_full = 1'b1;
        m_out  = it.data;
        m_sel  = g;
        if (mode == 1'b1) m_rr = g;
      end
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input logic md, input logic [SEL_W-1:0] o,
                     input logic [NUM_IN-1:0] v, input logic ordy);
    mode      = md;
    op        = o;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset     = 1'b0;
    mode      = 1'b0;
    op        = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
    m_full = 1'b0;
    m_out  = '0;
    m_sel  = '0;
    m_rr   = SEL_W'(NUM_IN - 1);
    #1;

    // Long reset, then release with nothing offered
    run(100, 1'b0, 2'd0, 4'b0000, 1'b0);
    reset = 1'b1;
    run(2, 1'b0, 2'd0, 4'b0000, 1'b0);

    // SELECT sweep
    for (int i = 0; i < NUM_IN; i++) run(1, 1'b0, SEL_W'(i), 4'b1111, 1'b1);
    run(1, 1'b0, 2'd0, 4'b0000, 1'b1);

    // ROUND_ROBIN, everyone valid
    run(8, 1'b1, 2'd0, 4'b1111, 1'b1);
    run(1, 1'b1, 2'd0, 4'b0000, 1'b1);

    // ROUND_ROBIN with backpressure
    run(3, 1'b1, 2'd0, 4'b1010, 1'b0);
    run(3, 1'b1, 2'd0, 4'b1010, 1'b1);
    run(2, 1'b1, 2'd0, 4'b0000, 1'b1);

    // SELECT on an idle channel, then it becomes valid
    run(2, 1'b0, 2'd2, 4'b1011, 1'b1);
    run(1, 1'b0, 2'd2, 4'b0100, 1'b1);
    run(2, 1'b0, 2'd2, 4'b0000, 1'b1);

    // Reset while holding an undelivered word
    run(1, 1'b0, 2'd1, 4'b0010, 1'b0);
    run(2, 1'b0, 2'd1, 4'b0000, 1'b0);
    reset = 1'b0;
    run(1, 1'b0, 2'd1, 4'b0010, 1'b1);
    reset = 1'b1;
    run(2, 1'b0, 2'd1, 4'b0000, 1'b1);

    // Random traffic with distinct per-channel data
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom};
      reset   = ($urandom_range(0, 49) != 0);
      run(1, 1'(($urandom_range(0, 1))), SEL_W'($urandom_range(0, NUM_IN - 1)),
          NUM_IN'($urandom), ($urandom_range(0, 3) != 0));
    end
    reset = 1'b1;
    run(3, 1'b0, 2'd0, 4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
